pll_frac_clkgen: RTL

// - Parametrised multi-channel clock-enable generator.
// - Successor to the fixed single-output PLL wrapper. It synthesises NCH independent

---
 rtl/pll_frac_clkgen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pll_frac_clkgen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel, relock on rate change.
// Optional PLL_FRAC_SQUARE_EN adds a per-channel square output (accumulator MSB).

module pll_frac_ch #(
  parameter int ACC_W    = 16,
  parameter int INIT_INC = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
`ifdef PLL_FRAC_SQUARE_EN
  output logic             msb,
`endif
  output logic             ce
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Accumulator is held at zero whenever not running so every channel restarts in phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      inc <= ACC_W'(INIT_INC);
      ce  <= 1'b0;
    end else begin
      if (load) inc <= load_inc;
      if (run) begin
        acc <= sum[ACC_W-1:0];
        ce  <= sum[ACC_W];
      end else begin
        acc <= '0;
        ce  <= 1'b0;
      end
    end
  end

`ifdef PLL_FRAC_SQUARE_EN
  assign msb = acc[ACC_W-1];
`endif
endmodule

module pll_frac_clkgen #(
  parameter int NCH         = 2,
  parameter int ACC_W       = 16,
  parameter int INIT_INC    = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic [NCH-1:0]   ce,
`ifdef PLL_FRAC_SQUARE_EN
  output logic [NCH-1:0]   square,
`endif
  output logic             locked
);
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {RELOCK, LOCKED} state_t;

  state_t         state, state_nx;
  logic [LCW-1:0] lock_cnt, lock_cnt_nx;
  logic           hit;
  logic           run;

  assign cfg_ready = (state == LOCKED);
  assign locked    = (state == LOCKED);
  // Writes to channels that do not exist complete the handshake but are dropped.
  assign hit = cfg_valid && cfg_ready && ({1'b0, cfg_ch} < 4'(NCH));
  assign run = (state == LOCKED) && !hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RELOCK;
      lock_cnt <= LCW'(LOCK_CYCLES);
    end else begin
      state    <= state_nx;
      lock_cnt <= lock_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    lock_cnt_nx = lock_cnt;
    case (state)
      RELOCK: begin
        lock_cnt_nx = lock_cnt - 1'b1;
        if (lock_cnt == LCW'(1)) state_nx = LOCKED;
      end
      LOCKED: begin
        if (hit) begin
          state_nx    = RELOCK;
          lock_cnt_nx = LCW'(LOCK_CYCLES);
        end
      end
      default: state_nx = RELOCK;
    endcase
  end

`ifdef PLL_FRAC_SQUARE_EN
  logic [NCH-1:0] msb;
  assign square = {NCH{locked}} & msb;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pll_frac_ch #(.ACC_W(ACC_W), .INIT_INC(INIT_INC)) u_ch (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .load     (hit && (cfg_ch == 3'(c))),
      .load_inc (cfg_inc),
`ifdef PLL_FRAC_SQUARE_EN
      .msb      (msb[c]),
`endif
      .ce       (ce[c])
    );
  end
endmodule
